fetch_seq: RTL and testbench

FETCH_SEQ -- requirements
Module: fetch_seq

---
 rtl/fetch_seq.sv | 149 ++++++++++++++
 tb/tb_fetch_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: FETCH -> LOAD -> EXEC loop with exception entry and halt.
// Optional fetch watchdog is compiled in when FETCH_TIMEOUT_EN is defined.
module fetch_seq #(
  parameter int                  BITS     = 32,
  parameter int                  PC_BITS  = 16,
  parameter logic [PC_BITS-1:0]  RESET_PC = '0,
  parameter logic [PC_BITS-1:0]  EXC_VEC  = 'h0040,
  parameter int                  TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_BITS-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [BITS-1:0]    imem_rdata,
  output logic               load_instr,
  output logic [BITS-1:0]    instr_data,
  input  logic               halt,
  input  logic               exception,
  input  logic               redirect,
  input  logic [PC_BITS-1:0] redirect_pc,
  output logic [PC_BITS-1:0] epc,
  output logic               halted,
  output logic               fetch_err
);

  localparam logic [BITS-1:0] NOP = BITS'(32'h0000_0020);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_EXEC,
    S_EXC,
    S_HALTED
  } state_e;

  state_e             state_q, state_d;
  logic [PC_BITS-1:0] pc_q, pc_d;
  logic [BITS-1:0]    instr_q, instr_d;
  logic [PC_BITS-1:0] epc_q, epc_d;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [3:0] WDOG_LAST = 4'(TIMEOUT - 1);

  logic [3:0] wdog_q, wdog_d;
  logic       wd_exc_q, wd_exc_d;
  logic       fetch_err_q, fetch_err_d;
`endif

  // NOTE: state registers use non-blocking assignments only; all next-state math lives in always_comb.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      epc_q   <= '0;
`ifdef FETCH_TIMEOUT_EN
      wdog_q      <= '0;
      wd_exc_q    <= 1'b0;
      fetch_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      epc_q   <= epc_d;
`ifdef FETCH_TIMEOUT_EN
      wdog_q      <= wdog_d;
      wd_exc_q    <= wd_exc_d;
      fetch_err_q <= fetch_err_d;
`endif
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    epc_d   = epc_q;
`ifdef FETCH_TIMEOUT_EN
    wdog_d      = '0;
    wd_exc_d    = wd_exc_q;
    fetch_err_d = fetch_err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          pc_d    = pc_q + PC_BITS'(1);
          state_d = S_LOAD;
        end
`ifdef FETCH_TIMEOUT_EN
        // The watchdog only advances while we stay here; leaving FETCH clears it via the default.
        else if (wdog_q == WDOG_LAST) begin
          state_d     = S_EXC;
          wd_exc_d    = 1'b1;
          fetch_err_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 4'd1;
        end
`endif
      end
      S_LOAD: state_d = S_EXEC;
      S_EXEC: begin
        if (exception) begin
          state_d = S_EXC;
        end else if (halt) begin
          state_d = S_HALTED;
        end else begin
          if (redirect) pc_d = redirect_pc;
          state_d = run ? S_FETCH : S_IDLE;
        end
      end
      S_EXC: begin
        // pc already points past the faulting instruction unless the fetch itself timed out.
`ifdef FETCH_TIMEOUT_EN
        epc_d    = wd_exc_q ? pc_q : pc_q - PC_BITS'(1);
        wd_exc_d = 1'b0;
`else
        epc_d = pc_q - PC_BITS'(1);
`endif
        pc_d    = EXC_VEC;
        state_d = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign load_instr = (state_q == S_LOAD);
  assign instr_data = instr_q;
  assign epc        = epc_q;
  assign halted     = (state_q == S_HALTED);

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq; fetched words go through a scoreboard queue.
// Watchdog expectations follow FETCH_TIMEOUT_EN as compiled.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic        run = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        load_instr;
  logic [31:0] instr_data;
  logic        halt = 1'b0;
  logic        exception = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] epc;
  logic        halted;
  logic        fetch_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];

  fetch_seq dut (
    .clk        (clk),
    .rst_       (rst_),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .load_instr (load_instr),
    .instr_data (instr_data),
    .halt       (halt),
    .exception  (exception),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .epc        (epc),
    .halted     (halted),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Waits (bounded) at negedges until a request is visible.
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (imem_req === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  // Serves one fetch with the given ack delay; returns observations, ends at the EXEC negedge.
  task automatic fetch_one(input logic [31:0] word, input int delay,
                           output logic [15:0] addr, output bit stable, output int req_cyc,
                           output bit load_at1, output int pulses, output logic [31:0] got,
                           output int start_cyc, output bit ok);
    wait_req(ok);
    addr = imem_addr; stable = 1'b1; req_cyc = 0; pulses = 0; load_at1 = 1'b0;
    got = '0; start_cyc = cyc;
    if (!ok) return;
    for (int i = 0; i <= delay; i++) begin
      if (imem_req !== 1'b1 || imem_addr !== addr) stable = 1'b0;
      else req_cyc++;
      pulses += int'(load_instr === 1'b1);
      if (i == delay) begin
        imem_ack = 1'b1; imem_rdata = word; exp_q.push_back(word);
      end else begin
        imem_ack = 1'b0; imem_rdata = $urandom;
      end
      @(negedge clk);
    end
    imem_ack = 1'b0; imem_rdata = $urandom;
    load_at1 = (load_instr === 1'b1);
    got = instr_data;
    pulses += int'(load_instr === 1'b1);
    @(negedge clk);
    pulses += int'(load_instr === 1'b1);
  endtask

  task automatic exec_step(input bit exc, input bit hlt, input bit red, input logic [15:0] rpc);
    exception = exc; halt = hlt; redirect = red; redirect_pc = rpc;
    @(negedge clk);
    exception = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = $urandom;
  endtask

  task automatic test_reset;
    rst_ = 1'b0;
    #1;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", imem_req); end
    vectors++; if (load_instr !== 1'b0) begin miscompares++; $display("FAIL reset_load: got %b want 0", load_instr); end
    vectors++; if (instr_data !== 32'h0000_0020) begin miscompares++; $display("FAIL reset_instr: got %h want 00000020", instr_data); end
    vectors++; if (epc !== 16'h0) begin miscompares++; $display("FAIL reset_epc: got %h want 0000", epc); end
    vectors++; if (halted !== 1'b0 || fetch_err !== 1'b0) begin miscompares++; $display("FAIL reset_flags: got halted=%b err=%b want 0 0", halted, fetch_err); end
    vectors++; if (imem_addr !== 16'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 0000", imem_addr); end
    @(negedge clk); @(negedge clk);
    rst_ = 1'b1;
  endtask

  task automatic test_basic;
    logic [15:0] addr; bit stable, l1, ok; int rc, pl, sc; logic [31:0] got, e;
    run = 1'b1;
    fetch_one(32'h2002_0005, 0, addr, stable, rc, l1, pl, got, sc, ok);
    vectors++; if (!ok || addr !== 16'h0) begin miscompares++; $display("FAIL basic_addr: got %h ok=%0d want 0000", addr, ok); end
    vectors++; if (!l1 || pl != 1) begin miscompares++; $display("FAIL basic_load: got first=%0d pulses=%0d want 1 1", l1, pl); end
    e = exp_q.size() ? exp_q.pop_front() : 32'hx;
    vectors++; if (got !== e) begin miscompares++; $display("FAIL basic_instr: got %h want %h", got, e); end
    exec_step(0, 0, 0, 16'h0);
    wait_req(ok);
    vectors++; if (!ok || imem_addr !== 16'h1) begin miscompares++; $display("FAIL basic_next_pc: got %h want 0001", imem_addr); end
    vectors++; if (cyc - sc != 3) begin miscompares++; $display("FAIL basic_cpi: got %0d want 3", cyc - sc); end
  endtask

  task automatic test_delayed_ack;
    logic [15:0] addr; bit stable, l1, ok; int rc, pl, sc; logic [31:0] got, e;
    fetch_one(32'hA5A5_1234, 4, addr, stable, rc, l1, pl, got, sc, ok);
    vectors++; if (!ok || addr !== 16'h1) begin miscompares++; $display("FAIL delay_addr: got %h want 0001", addr); end
    vectors++; if (!stable || rc != 5) begin miscompares++; $display("FAIL delay_stable: got stable=%0d cycles=%0d want 1 5", stable, rc); end
    vectors++; if (!l1 || pl != 1) begin miscompares++; $display("FAIL delay_load: got first=%0d pulses=%0d want 1 1", l1, pl); end
    e = exp_q.size() ? exp_q.pop_front() : 32'hx;
    vectors++; if (got !== e) begin miscompares++; $display("FAIL delay_instr: got %h want %h", got, e); end
    exec_step(0, 0, 0, 16'h0);
  endtask

  task automatic test_run_drop;
    logic [15:0] addr; bit stable, l1, ok, idle_ok; int rc, pl, sc; logic [31:0] got, e;
    wait_req(ok);
    run = 1'b0;
    fetch_one(32'h0BAD_F00D, 1, addr, stable, rc, l1, pl, got, sc, ok);
    e = exp_q.size() ? exp_q.pop_front() : 32'hx;
    vectors++; if (!ok || addr !== 16'h2 || got !== e || pl != 1) begin miscompares++; $display("FAIL drop_inflight: got addr=%h instr=%h pulses=%0d want 0002 %h 1", addr, got, pl, e); end
    exec_step(0, 0, 0, 16'h0);
    idle_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (imem_req !== 1'b0) idle_ok = 1'b0;
      @(negedge clk);
    end
    vectors++; if (!idle_ok) begin miscompares++; $display("FAIL drop_idle: got req while idle want 0"); end
  endtask

  task automatic test_ignore;
    bit ok, quiet;
    imem_ack = 1'b1; halt = 1'b1; exception = 1'b1; redirect = 1'b1; redirect_pc = 16'h5555;
    quiet = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b0 || halted !== 1'b0 || load_instr !== 1'b0) quiet = 1'b0;
    end
    imem_ack = 1'b0; halt = 1'b0; exception = 1'b0; redirect = 1'b0;
    vectors++; if (!quiet || epc !== 16'h0) begin miscompares++; $display("FAIL ignore_idle: got quiet=%0d epc=%h want 1 0000", quiet, epc); end
    run = 1'b1;
    wait_req(ok);
    vectors++; if (!ok || imem_addr !== 16'h3) begin miscompares++; $display("FAIL ignore_pc: got %h want 0003", imem_addr); end
  endtask

  task automatic test_redirect_exception;
    logic [15:0] addr; bit stable, l1, ok; int rc, pl, sc; logic [31:0] got, e;
    fetch_one(32'h1111_0003, 0, addr, stable, rc, l1, pl, got, sc, ok);
    e = exp_q.size() ? exp_q.pop_front() : 32'hx;
    vectors++; if (got !== e) begin miscompares++; $display("FAIL redir_instr: got %h want %h", got, e); end
    exec_step(0, 0, 1, 16'h0007);
    wait_req(ok);
    vectors++; if (!ok || imem_addr !== 16'h7) begin miscompares++; $display("FAIL redir_pc: got %h want 0007", imem_addr); end
    fetch_one(32'h7777_0007, 0, addr, stable, rc, l1, pl, got, sc, ok);
    e = exp_q.size() ? exp_q.pop_front() : 32'hx;
    vectors++; if (got !== e) begin miscompares++; $display("FAIL exc_instr: got %h want %h", got, e); end
    exec_step(1, 1, 1, 16'h0100);
    vectors++; if (imem_req !== 1'b0 || halted !== 1'b0) begin miscompares++; $display("FAIL exc_state: got req=%b halted=%b want 0 0", imem_req, halted); end
    @(negedge clk);
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin miscompares++; $display("FAIL exc_vec: got req=%b addr=%h want 1 0040", imem_req, imem_addr); end
    vectors++; if (epc !== 16'h7) begin miscompares++; $display("FAIL exc_epc: got %h want 0007", epc); end
  endtask

  task automatic test_wrap;
    logic [15:0] addr; bit stable, l1, ok; int rc, pl, sc; logic [31:0] got, e;
    fetch_one(32'h4040_4040, 0, addr, stable, rc, l1, pl, got, sc, ok);
    e = exp_q.size() ? exp_q.pop_front() : 32'hx;
    vectors++; if (got !== e) begin miscompares++; $display("FAIL wrap_vec_instr: got %h want %h", got, e); end
    exec_step(0, 0, 1, 16'hFFFF);
    fetch_one(32'hFFFF_0001, 0, addr, stable, rc, l1, pl, got, sc, ok);
    vectors++; if (!ok || addr !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_top: got %h want ffff", addr); end
    e = exp_q.size() ? exp_q.pop_front() : 32'hx;
    vectors++; if (got !== e) begin miscompares++; $display("FAIL wrap_instr: got %h want %h", got, e); end
    exec_step(0, 0, 0, 16'h0);
    wait_req(ok);
    vectors++; if (!ok || imem_addr !== 16'h0 || fetch_err !== 1'b0) begin miscompares++; $display("FAIL wrap_zero: got addr=%h err=%b want 0000 0", imem_addr, fetch_err); end
  endtask

  task automatic test_watchdog;
    logic [15:0] addr; bit stable, l1, ok; int rc, pl, sc, n; logic [31:0] got, e;
    fetch_one(32'h0000_0020, 0, addr, stable, rc, l1, pl, got, sc, ok);
    void'(exp_q.pop_front());
    exec_step(0, 0, 1, 16'h0003);
    wait_req(ok);
    vectors++; if (!ok || imem_addr !== 16'h3) begin miscompares++; $display("FAIL wd_setup: got %h want 0003", imem_addr); end
`ifdef FETCH_TIMEOUT_EN
    n = 0;
    while (imem_req === 1'b1 && n < 40) begin n++; @(negedge clk); end
    vectors++; if (n != 15) begin miscompares++; $display("FAIL wd_cycles: got %0d want 15", n); end
    @(negedge clk);
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin miscompares++; $display("FAIL wd_vec: got req=%b addr=%h want 1 0040", imem_req, imem_addr); end
    vectors++; if (epc !== 16'h3 || fetch_err !== 1'b1) begin miscompares++; $display("FAIL wd_epc: got epc=%h err=%b want 0003 1", epc, fetch_err); end
    fetch_one(32'hC0DE_0040, 0, addr, stable, rc, l1, pl, got, sc, ok);
    e = exp_q.size() ? exp_q.pop_front() : 32'hx;
    vectors++; if (got !== e || fetch_err !== 1'b1) begin miscompares++; $display("FAIL wd_resume: got instr=%h err=%b want %h 1", got, fetch_err, e); end
`else
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req === 1'b1 && imem_addr === 16'h3) n++;
      @(negedge clk);
    end
    vectors++; if (n != 20 || fetch_err !== 1'b0) begin miscompares++; $display("FAIL wd_wait: got held=%0d err=%b want 20 0", n, fetch_err); end
    fetch_one(32'hC0DE_0003, 0, addr, stable, rc, l1, pl, got, sc, ok);
    e = exp_q.size() ? exp_q.pop_front() : 32'hx;
    vectors++; if (got !== e) begin miscompares++; $display("FAIL wd_resume: got %h want %h", got, e); end
`endif
    exec_step(0, 0, 0, 16'h0);
  endtask

  task automatic test_halt;
    logic [15:0] addr; bit stable, l1, ok, quiet; int rc, pl, sc; logic [31:0] got;
    fetch_one(32'h0000_0001, 0, addr, stable, rc, l1, pl, got, sc, ok);
    void'(exp_q.pop_front());
    exec_step(0, 1, 1, 16'h0100);
    vectors++; if (halted !== 1'b1 || imem_req !== 1'b0) begin miscompares++; $display("FAIL halt_enter: got halted=%b req=%b want 1 0", halted, imem_req); end
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b0 || halted !== 1'b1) quiet = 1'b0;
    end
    vectors++; if (!quiet) begin miscompares++; $display("FAIL halt_stay: got activity after halt want none"); end
  endtask

  task automatic test_reset_mid_fetch;
    logic [15:0] addr; bit stable, l1, ok; int rc, pl, sc; logic [31:0] got;
    rst_ = 1'b0;
    @(negedge clk);
    rst_ = 1'b1; run = 1'b1;
    fetch_one(32'hDEAD_BEEF, 0, addr, stable, rc, l1, pl, got, sc, ok);
    void'(exp_q.pop_front());
    vectors++; if (!ok || addr !== 16'h0 || got !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rst_restart: got addr=%h instr=%h want 0000 deadbeef", addr, got); end
    exec_step(0, 0, 0, 16'h0);
    wait_req(ok);
    #2 rst_ = 1'b0;
    #1;
    vectors++; if (imem_req !== 1'b0 || instr_data !== 32'h0000_0020) begin miscompares++; $display("FAIL rst_async: got req=%b instr=%h want 0 00000020", imem_req, instr_data); end
    @(negedge clk);
    run = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    rst_ = 1'b1;
    @(negedge clk);
    vectors++; if (imem_req !== 1'b0 || load_instr !== 1'b0 || instr_data !== 32'h0000_0020) begin miscompares++; $display("FAIL rst_late_ack: got req=%b load=%b instr=%h want 0 0 00000020", imem_req, load_instr, instr_data); end
    imem_ack = 1'b0; run = 1'b1;
    wait_req(ok);
    vectors++; if (!ok || imem_addr !== 16'h0) begin miscompares++; $display("FAIL rst_pc: got %h want 0000", imem_addr); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_delayed_ack();
    test_run_drop();
    test_ignore();
    test_redirect_exception();
    test_wrap();
    test_watchdog();
    test_halt();
    test_reset_mid_fetch();
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
